latent_sampler: RTL and testbench

Reparameterisation stage directly downstream of the fixed-point encoder. It consumes the encoder's flattened output vector, which holds LATENT means followed by LATENT log-variances. For each latent element it produces z = mu + sigma·eps, where sigma ≈ exp(logvar/2) and eps is pseudo-random noise from an internal LFSR. Elements are processed serially through one multiplier, and the result vector is presented under a valid/ready handshake to the decoder stage.

---
 rtl/latent_sampler_pkg.sv | 16 +
 rtl/latent_sampler_lfsr16.sv | 33 +++
 rtl/latent_sampler.sv | 145 ++++++++++++++
 tb/tb_latent_sampler.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latent_sampler_pkg.sv
// Shared Q16.16 constants, LFSR taps and FSM encodings for the reparameterisation sampler.
package latent_sampler_pkg;

   localparam int Q_FRAC     = 16;
   localparam int LFSR_W     = 16;
   localparam int LV_MAX_INT = 4;

   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/latent_sampler_lfsr16.sv
// 16-bit right-shifting Galois LFSR; advances one step per cycle with en high, otherwise holds.
// Asynchronous active-low reset reloads the seed.
module lfsr16
   import latent_sampler_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (en) begin
         state_d = {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? LFSR_TAPS : '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= seed;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/latent_sampler.sv
// z = mu + exp(logvar/2)*eps per latent element, one element per cycle; out_valid LATENT+1 cycles from accept.
// DONE holds z, out_valid and the LFSR until out_ready; input is accepted only in IDLE.
module latent_sampler
   import latent_sampler_pkg::*;
#(
   parameter int               LATENT    = 2,
   parameter int               BITSIZE   = 32,
   parameter int               FRAC      = Q_FRAC,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [2*LATENT*BITSIZE-1:0] enc_in,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [LATENT*BITSIZE-1:0]   z,
   output logic                        out_valid,
   input  logic                        out_ready
);

   localparam int IDXW = (LATENT > 1) ? $clog2(LATENT) : 1;
   localparam int PW   = 2 * BITSIZE;

   typedef logic signed [BITSIZE-1:0] word_t;
   typedef logic signed [PW-1:0]      wide_t;

   localparam word_t SAT_HI = {1'b0, {(BITSIZE-1){1'b1}}};
   localparam word_t SAT_LO = {1'b1, {(BITSIZE-1){1'b0}}};
   localparam word_t ONE_W  = word_t'(1) <<< FRAC;
   localparam word_t LV_HI  = word_t'(LV_MAX_INT) <<< FRAC;
   localparam word_t LV_LO  = -LV_HI;

   function automatic wide_t widen(input word_t a);
      return {{BITSIZE{a[BITSIZE-1]}}, a};
   endfunction

   // In range exactly when the discarded top bits all match the new sign bit.
   function automatic word_t narrow_sat(input wide_t v);
      logic [BITSIZE:0] top;
      top = v[PW-1:BITSIZE-1];
      if ((&top) || !(|top)) begin
         return v[BITSIZE-1:0];
      end
      return v[PW-1] ? SAT_LO : SAT_HI;
   endfunction

   function automatic word_t mul_q(input word_t a, input word_t b);
      wide_t p;
      p = (widen(a) * widen(b)) >>> FRAC;
      return narrow_sat(p);
   endfunction

   function automatic word_t add_sat(input word_t a, input word_t b);
      word_t s;
      s = a + b;
      if ((a[BITSIZE-1] == b[BITSIZE-1]) && (s[BITSIZE-1] != a[BITSIZE-1])) begin
         return a[BITSIZE-1] ? SAT_LO : SAT_HI;
      end
      return s;
   endfunction

   state_t                        state_q, state_d;
   logic [IDXW-1:0]               idx_q, idx_d;
   logic [2*LATENT*BITSIZE-1:0]   enc_q, enc_d;
   logic [LATENT*BITSIZE-1:0]     z_q, z_d;
   logic [LFSR_W-1:0]             lfsr_state;
   logic                          calc;
   word_t                         mu, lv_raw, lv, h, sigma, eps, z_new;

   assign calc = (state_q == ST_CALC);

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (calc),
      .seed  (LFSR_SEED),
      .state (lfsr_state)
   );

   // sigma is the 2nd-order Taylor series of exp(h); with |h| <= 2 it stays >= 0.5.
   always_comb begin
      mu     = enc_q[int'(idx_q)*BITSIZE +: BITSIZE];
      lv_raw = enc_q[(LATENT+int'(idx_q))*BITSIZE +: BITSIZE];
      if (lv_raw > LV_HI) begin
         lv = LV_HI;
      end else if (lv_raw < LV_LO) begin
         lv = LV_LO;
      end else begin
         lv = lv_raw;
      end
      h     = lv >>> 1;
      sigma = ONE_W + h + (mul_q(h, h) >>> 1);
      eps   = {{(BITSIZE-LFSR_W){lfsr_state[LFSR_W-1]}}, lfsr_state};
      z_new = add_sat(mu, mul_q(sigma, eps));
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      enc_d   = enc_q;
      z_d     = z_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               enc_d   = enc_in;
               idx_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            z_d[int'(idx_q)*BITSIZE +: BITSIZE] = z_new;
            if (idx_q == IDXW'(LATENT-1)) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         enc_q   <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         enc_q   <= enc_d;
         z_q     <= z_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign z         = z_q;

endmodule

// File: tb/tb_latent_sampler.sv
// Bench for latent_sampler: three instances with different seeds share stimulus and are checked
// against an arithmetic reference of the reparameterisation rules.
module tb_latent_sampler;

   localparam int LATENT = 2;
   localparam int BW     = 32;
   localparam int NI     = 3;
   localparam longint QMAX = 64'sh7FFFFFFF;
   localparam longint QMIN = -64'sh80000000;

   logic                       clk = 1'b0;
   logic                       rst = 1'b0;
   logic [2*LATENT*BW-1:0]     enc_in = '0;
   logic                       in_valid = 1'b0;
   logic                       out_ready = 1'b1;

   logic [LATENT*BW-1:0]       z_w  [NI];
   logic                       ir_w [NI];
   logic                       ov_w [NI];

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] m_lfsr [NI];
   logic [31:0] exp_z  [NI][LATENT];

   always #5 clk = ~clk;

   latent_sampler #(.LATENT(LATENT), .BITSIZE(BW), .FRAC(16), .LFSR_SEED(16'hACE1)) u_dut (
      .clk(clk), .rst(rst), .enc_in(enc_in), .in_valid(in_valid), .in_ready(ir_w[0]),
      .z(z_w[0]), .out_valid(ov_w[0]), .out_ready(out_ready));

   latent_sampler #(.LATENT(LATENT), .BITSIZE(BW), .FRAC(16), .LFSR_SEED(16'h4000)) u_dut_c (
      .clk(clk), .rst(rst), .enc_in(enc_in), .in_valid(in_valid), .in_ready(ir_w[1]),
      .z(z_w[1]), .out_valid(ov_w[1]), .out_ready(out_ready));

   latent_sampler #(.LATENT(LATENT), .BITSIZE(BW), .FRAC(16), .LFSR_SEED(16'h7FFF)) u_dut_s (
      .clk(clk), .rst(rst), .enc_in(enc_in), .in_valid(in_valid), .in_ready(ir_w[2]),
      .z(z_w[2]), .out_valid(ov_w[2]), .out_ready(out_ready));

   function automatic logic [15:0] seed_of(input int i);
      case (i)
         0:       return 16'hACE1;
         1:       return 16'h4000;
         default: return 16'h7FFF;
      endcase
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   function automatic longint clamp32(input longint v);
      if (v > QMAX) return QMAX;
      if (v < QMIN) return QMIN;
      return v;
   endfunction

   // Reference: z = sat(mu + sat(floor(sigma*eps / 2^16))), sigma = 1 + h + floor(h^2 / 2^17).
   function automatic logic [31:0] ref_z(input logic [31:0] mu, input logic [31:0] lv, input logic [15:0] st);
      longint l, h, sig, e, p, s;
      l = longint'($signed(lv));
      if (l > 262144) l = 262144;
      else if (l < -262144) l = -262144;
      h   = l >>> 1;
      sig = 65536 + h + ((h * h) >>> 17);
      e   = longint'($signed(st));
      p   = clamp32((sig * e) >>> 16);
      s   = clamp32(longint'($signed(mu)) + p);
      return s[31:0];
   endfunction

   function automatic logic [2*LATENT*BW-1:0] rand_enc();
      logic [2*LATENT*BW-1:0] v;
      logic [31:0] lv;
      for (int k = 0; k < LATENT; k++) begin
         v[k*BW +: BW] = $urandom;
         if ($urandom_range(0, 1) == 1) lv = $urandom;
         else lv = $urandom_range(0, 32'h000A0000) - 32'h00050000;
         v[(LATENT+k)*BW +: BW] = lv;
      end
      return v;
   endfunction

   task automatic predict(input logic [2*LATENT*BW-1:0] enc);
      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < LATENT; k++) begin
            exp_z[i][k] = ref_z(enc[k*BW +: BW], enc[(LATENT+k)*BW +: BW], m_lfsr[i]);
            m_lfsr[i]   = lfsr_next(m_lfsr[i]);
         end
      end
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < NI; i++) m_lfsr[i] = seed_of(i);
   endtask

   // Called in IDLE; returns edges counted from the accept edge (=1) to out_valid, or -1 on timeout.
   task automatic send_and_wait(input logic [2*LATENT*BW-1:0] enc, output int cyc);
      enc_in   = enc;
      in_valid = 1'b1;
      predict(enc);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc = 1;
      while (ov_w[0] !== 1'b1 && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (ov_w[0] !== 1'b1) cyc = -1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (ir_w[i] !== 1'b1 || ov_w[i] !== 1'b0 || z_w[i] !== '0) begin
               n_bad++;
               $display("FAIL reset_idle inst%0d cyc%0d: got rdy=%b vld=%b z=%h want rdy=1 vld=0 z=0",
                        i, c, ir_w[i], ov_w[i], z_w[i]);
            end
         end
      end
   endtask

   task automatic test_basic();
      int cyc;
      send_and_wait({32'h0, 32'h0, 32'h0, 32'h00010000}, cyc);
      n_cmp++;
      if (cyc !== LATENT + 1) begin
         n_bad++;
         $display("FAIL basic_latency: got %0d want %0d", cyc, LATENT + 1);
      end
      n_cmp++;
      if (z_w[0][31:0] !== 32'h0000ACE1) begin
         n_bad++;
         $display("FAIL basic_z0: got %h want 0000ace1", z_w[0][31:0]);
      end
      n_cmp++;
      if (z_w[0][63:32] !== 32'hFFFFE270) begin
         n_bad++;
         $display("FAIL basic_z1: got %h want ffffe270", z_w[0][63:32]);
      end
      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < LATENT; k++) begin
            n_cmp++;
            if (z_w[i][k*BW +: BW] !== exp_z[i][k]) begin
               n_bad++;
               $display("FAIL basic_model inst%0d z%0d: got %h want %h", i, k, z_w[i][k*BW +: BW], exp_z[i][k]);
            end
         end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (ir_w[0] !== 1'b1 || ov_w[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL basic_return_idle: got rdy=%b vld=%b want rdy=1 vld=0", ir_w[0], ov_w[0]);
      end
   endtask

   task automatic test_clamp();
      int cyc;
      logic [2*LATENT*BW-1:0] enc;
      do_reset();
      enc = rand_enc();
      enc[0 +: BW]          = 32'h0;
      enc[LATENT*BW +: BW]  = 32'h000A0000;
      send_and_wait(enc, cyc);
      n_cmp++;
      if (z_w[1][31:0] !== 32'h00014000) begin
         n_bad++;
         $display("FAIL clamp_z0: got %h want 00014000", z_w[1][31:0]);
      end
      for (int i = 0; i < NI; i++) begin
         n_cmp++;
         if (z_w[i] !== {exp_z[i][1], exp_z[i][0]}) begin
            n_bad++;
            $display("FAIL clamp_model inst%0d: got %h want %h", i, z_w[i], {exp_z[i][1], exp_z[i][0]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_saturation();
      int cyc;
      logic [2*LATENT*BW-1:0] enc;
      do_reset();
      enc = rand_enc();
      enc[0 +: BW]         = 32'h7FFF0000;
      enc[LATENT*BW +: BW] = 32'h00040000;
      send_and_wait(enc, cyc);
      n_cmp++;
      if (z_w[2][31:0] !== 32'h7FFFFFFF) begin
         n_bad++;
         $display("FAIL sat_z0: got %h want 7fffffff", z_w[2][31:0]);
      end
      for (int i = 0; i < NI; i++) begin
         n_cmp++;
         if (z_w[i] !== {exp_z[i][1], exp_z[i][0]}) begin
            n_bad++;
            $display("FAIL sat_model inst%0d: got %h want %h", i, z_w[i], {exp_z[i][1], exp_z[i][0]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int cyc;
      int hold;
      for (int v = 0; v < 20; v++) begin
         out_ready = 1'b0;
         send_and_wait(rand_enc(), cyc);
         n_cmp++;
         if (cyc !== LATENT + 1) begin
            n_bad++;
            $display("FAIL rand_latency v%0d: got %0d want %0d", v, cyc, LATENT + 1);
         end
         for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (z_w[i] !== {exp_z[i][1], exp_z[i][0]}) begin
               n_bad++;
               $display("FAIL rand_model v%0d inst%0d: got %h want %h", v, i, z_w[i], {exp_z[i][1], exp_z[i][0]});
            end
         end
         hold = $urandom_range(0, 3);
         repeat (hold) @(posedge clk);
         #1;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         n_cmp++;
         if (ir_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rand_release v%0d: got rdy=%b want 1", v, ir_w[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [LATENT*BW-1:0] snap;
      out_ready = 1'b0;
      send_and_wait(rand_enc(), cyc);
      snap = {exp_z[0][1], exp_z[0][0]};
      for (int c = 0; c < 20; c++) begin
         in_valid = $urandom_range(0, 1);
         enc_in   = rand_enc();
         @(posedge clk);
         #1;
         n_cmp++;
         if (z_w[0] !== snap || ir_w[0] !== 1'b0 || ov_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold cyc%0d: got z=%h rdy=%b vld=%b want z=%h rdy=0 vld=1",
                     c, z_w[0], ir_w[0], ov_w[0], snap);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (ov_w[0] !== 1'b0 || ir_w[0] !== 1'b1 || z_w[0] !== snap) begin
         n_bad++;
         $display("FAIL bp_release: got z=%h rdy=%b vld=%b want z=%h rdy=1 vld=0", z_w[0], ir_w[0], ov_w[0], snap);
      end
      send_and_wait(rand_enc(), cyc);
      for (int i = 0; i < NI; i++) begin
         n_cmp++;
         if (z_w[i] !== {exp_z[i][1], exp_z[i][0]}) begin
            n_bad++;
            $display("FAIL bp_next_vector inst%0d: got %h want %h", i, z_w[i], {exp_z[i][1], exp_z[i][0]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int cnt;
      logic [2*LATENT*BW-1:0] enc;
      out_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         enc      = rand_enc();
         enc_in   = enc;
         in_valid = 1'b1;
         predict(enc);
         cnt = 0;
         do begin
            @(posedge clk);
            #1;
            cnt++;
         end while (ov_w[0] !== 1'b1 && cnt < 50);
         n_cmp++;
         if (cnt !== ((v == 0) ? LATENT + 1 : LATENT + 2)) begin
            n_bad++;
            $display("FAIL b2b_period v%0d: got %0d want %0d", v, cnt, (v == 0) ? LATENT + 1 : LATENT + 2);
         end
         for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (z_w[i] !== {exp_z[i][1], exp_z[i][0]}) begin
               n_bad++;
               $display("FAIL b2b_model v%0d inst%0d: got %h want %h", v, i, z_w[i], {exp_z[i][1], exp_z[i][0]});
            end
         end
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int cyc;
      logic [2*LATENT*BW-1:0] enc;
      enc      = {32'h0, 32'h0, 32'h0, 32'h00010000};
      enc_in   = enc;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         n_cmp++;
         if (ov_w[i] !== 1'b0 || ir_w[i] !== 1'b1 || z_w[i] !== '0) begin
            n_bad++;
            $display("FAIL midreset_clear inst%0d: got vld=%b rdy=%b z=%h want vld=0 rdy=1 z=0",
                     i, ov_w[i], ir_w[i], z_w[i]);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < NI; i++) m_lfsr[i] = seed_of(i);
      send_and_wait(enc, cyc);
      n_cmp++;
      if (z_w[0] !== {32'hFFFFE270, 32'h0000ACE1}) begin
         n_bad++;
         $display("FAIL midreset_reseed: got %h want ffffe2700000ace1", z_w[0]);
      end
      n_cmp++;
      if (cyc !== LATENT + 1) begin
         n_bad++;
         $display("FAIL midreset_latency: got %0d want %0d", cyc, LATENT + 1);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_saturation();
      do_reset();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
